// File: rtl/layer_sequencer_if.sv
// Purpose : signal bundle between host/accelerator and layer_sequencer.
// Latency : none, wires only.
// Backpressure: none; run_busy tells the host when config and run_start are ignored.
// Ports    : cfg_* descriptor writes, run_*/abort run control, neuron_done from the
//            accelerator, acc_* accelerator programming, buf_sel/layer_idx/status out.
//            master = host/accelerator side, slave = sequencer side.
interface layer_sequencer_if #(
   parameter int MAX_LAYERS = 4,
   parameter int AW         = 16
);
   localparam int LW = $clog2(MAX_LAYERS);

   logic          cfg_we;
   logic [LW-1:0] cfg_layer;
   logic [1:0]    cfg_field;
   logic [AW-1:0] cfg_data;
   logic          run_start;
   logic [LW:0]   run_layers;
   logic          abort;
   logic          neuron_done;

   logic [AW-1:0] acc_base_addr;
   logic [AW-1:0] acc_in_neurons;
   logic [AW-1:0] acc_out_neurons;
   logic          acc_start;
   logic          acc_enable;
   logic          buf_sel;
   logic [LW-1:0] layer_idx;
   logic          run_busy;
   logic          run_done;
   logic          err_skip;
   logic [31:0]   perf_cycles;

   modport master (
      output cfg_we, cfg_layer, cfg_field, cfg_data, run_start, run_layers, abort, neuron_done,
      input  acc_base_addr, acc_in_neurons, acc_out_neurons, acc_start, acc_enable,
             buf_sel, layer_idx, run_busy, run_done, err_skip, perf_cycles
   );

   modport slave (
      input  cfg_we, cfg_layer, cfg_field, cfg_data, run_start, run_layers, abort, neuron_done,
      output acc_base_addr, acc_in_neurons, acc_out_neurons, acc_start, acc_enable,
             buf_sel, layer_idx, run_busy, run_done, err_skip, perf_cycles
   );
endinterface

// File: rtl/layer_sequencer.sv
// Purpose : runs a multi-layer network on one accelerator, one descriptor per layer.
// Latency : acc_start visible 2 cycles after run_start is sampled; 3 cycles layer-to-layer.
// Backpressure: none; cfg writes and run_start are dropped while a run is active.
// Ports   : i_clk, i_rst_n (async, active-low), bus (layer_sequencer_if.slave).
// Option  : define LAYER_SEQ_PERF_EN to build the busy-cycle counter on perf_cycles.
module layer_sequencer #(
   parameter int MAX_LAYERS = 4,
   parameter int AW         = 16
) (
   input logic              i_clk,
   input logic              i_rst_n,
   layer_sequencer_if.slave bus
);
   localparam int          LW      = $clog2(MAX_LAYERS);
   localparam logic [LW:0] MAX_CNT = (LW+1)'(MAX_LAYERS);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_NEXT, S_DONE} state_t;
   state_t r_state, w_next;

   logic [AW-1:0] r_tbl_base [MAX_LAYERS];
   logic [AW-1:0] r_tbl_in   [MAX_LAYERS];
   logic [AW-1:0] r_tbl_out  [MAX_LAYERS];

   logic [AW-1:0] r_acc_base, r_acc_in, r_acc_out, r_cnt;
   logic          r_acc_start, r_busy, r_done, r_skip, r_buf, r_exec;
   logic [LW-1:0] r_layer;
   logic [LW:0]   r_nlayers;

   logic          w_idle, w_go, w_zero_run, w_tbl_zero, w_last_nd, w_last_layer, w_abort;
   logic [AW-1:0] w_cnt_inc;

   // IDLE with r_busy still set is the cycle right after DONE; the host still
   // sees run_busy there, so config and run_start stay locked for that cycle too.
   assign w_idle       = (r_state == S_IDLE) && !r_busy;
   assign w_go         = w_idle && bus.run_start && (bus.run_layers != '0);
   assign w_zero_run   = w_idle && bus.run_start && (bus.run_layers == '0);
   assign w_abort      = (r_state != S_IDLE) && bus.abort;
   assign w_tbl_zero   = (r_tbl_in[r_layer] == '0) || (r_tbl_out[r_layer] == '0);
   assign w_cnt_inc    = r_cnt + 1'b1;
   assign w_last_nd    = (r_state == S_WAIT) && bus.neuron_done && (w_cnt_inc == r_acc_out);
   assign w_last_layer = (({1'b0, r_layer} + 1'b1) == r_nlayers);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_go) w_next = S_LOAD;
         S_LOAD:  w_next = w_tbl_zero ? S_NEXT : S_START;
         S_START: w_next = S_WAIT;
         S_WAIT:  if (w_last_nd) w_next = S_NEXT;
         S_NEXT:  w_next = w_last_layer ? S_DONE : S_LOAD;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (w_abort) w_next = S_IDLE;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < MAX_LAYERS; i++) begin
            r_tbl_base[i] <= '0;
            r_tbl_in[i]   <= '0;
            r_tbl_out[i]  <= '0;
         end
         r_acc_base  <= '0;
         r_acc_in    <= '0;
         r_acc_out   <= '0;
         r_cnt       <= '0;
         r_acc_start <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_skip      <= 1'b0;
         r_buf       <= 1'b0;
         r_exec      <= 1'b0;
         r_layer     <= '0;
         r_nlayers   <= '0;
      end else begin
         if (w_idle && bus.cfg_we) begin
            case (bus.cfg_field)
               2'd0:    r_tbl_base[bus.cfg_layer] <= bus.cfg_data;
               2'd1:    r_tbl_in[bus.cfg_layer]   <= bus.cfg_data;
               2'd2:    r_tbl_out[bus.cfg_layer]  <= bus.cfg_data;
               default: ;
            endcase
         end

         // Status outputs are registered views of the state; abort clears them
         // on the same edge that the FSM returns to IDLE.
         r_acc_start <= (r_state == S_START) && !bus.abort;
         r_busy      <= (r_state != S_IDLE) && !bus.abort;
         r_done      <= ((r_state == S_DONE) && !bus.abort) || w_zero_run;

         if (w_go) begin
            r_layer   <= '0;
            r_buf     <= 1'b0;
            r_skip    <= 1'b0;
            r_nlayers <= (bus.run_layers > MAX_CNT) ? MAX_CNT : bus.run_layers;
         end

         if ((r_state == S_LOAD) && !bus.abort) begin
            r_acc_base <= r_tbl_base[r_layer];
            r_acc_in   <= r_tbl_in[r_layer];
            r_acc_out  <= r_tbl_out[r_layer];
            r_cnt      <= '0;
            r_exec     <= !w_tbl_zero;
            if (w_tbl_zero) r_skip <= 1'b1;
         end

         if ((r_state == S_WAIT) && bus.neuron_done) r_cnt <= w_cnt_inc;

         if ((r_state == S_NEXT) && !bus.abort) begin
            // Skipped layers wrote nothing, so the ping-pong side stays put.
            if (r_exec) r_buf <= ~r_buf;
            if (!w_last_layer) r_layer <= r_layer + 1'b1;
         end
      end
   end

`ifdef LAYER_SEQ_PERF_EN
   logic [31:0] r_perf;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                       r_perf <= '0;
      else if (w_go)                      r_perf <= '0;
      else if (r_busy && (r_perf != '1))  r_perf <= r_perf + 1'b1;
   end

   assign bus.perf_cycles = r_perf;
`else
   assign bus.perf_cycles = '0;
`endif

   assign bus.acc_base_addr   = r_acc_base;
   assign bus.acc_in_neurons  = r_acc_in;
   assign bus.acc_out_neurons = r_acc_out;
   assign bus.acc_start       = r_acc_start;
   assign bus.acc_enable      = r_busy;
   assign bus.run_busy        = r_busy;
   assign bus.run_done        = r_done;
   assign bus.err_skip        = r_skip;
   assign bus.buf_sel         = r_buf;
   assign bus.layer_idx       = r_layer;
endmodule
